// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the streaming UART transmitter.
//   uart_tx_state_t  : transmitter FSM state encoding
//   clks_per_bit()   : bit-time length in system clocks (integer truncation)
//   MIN_CLKS_PER_BIT : smallest bit-time the transmitter can time correctly
// Build option: UART_TX_STREAM_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

   // The end-of-frame pulse is raised one clk before the divider wraps,
   // so a bit-time needs at least two clks.
   localparam int MIN_CLKS_PER_BIT = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_STREAM_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4,
      GAP    = 3'd5
   } uart_tx_state_t;

   function automatic int clks_per_bit(input int clockRate, input int baudRate);
      return clockRate / baudRate;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with show-ahead read: rdata always presents the head entry
// while the FIFO is non-empty, so a pop consumes the word already visible.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, wdata    : write request (ignored while full)
//   pop, rdata     : read request (ignored while empty), head word
//   full, empty    : occupancy flags derived from the registered count
//   count          : number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtrReg;
   logic [PTR_W-1:0] rdPtrReg;
   logic [PTR_W:0]   countReg;
   logic             doPush;
   logic             doPop;

   // Full is judged on the registered count, so a pop on a full FIFO does not
   // free a slot for a push on the same edge.
   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   // Storage has no reset; a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtrReg] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
         countReg <= '0;
      end else begin
         if (doPush) begin
            wrPtrReg <= wrPtrReg + PTR_W'(1);
         end
         if (doPop) begin
            rdPtrReg <= rdPtrReg + PTR_W'(1);
         end
         case ({doPush, doPop})
            2'b10:   countReg <= countReg + (PTR_W+1)'(1);
            2'b01:   countReg <= countReg - (PTR_W+1)'(1);
            default: countReg <= countReg;
         endcase
      end
   end

   assign rdata = mem[rdPtrReg];
   assign full  = (countReg == FULL_COUNT);
   assign empty = (countReg == '0);
   assign count = countReg;

endmodule

// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
// FIFO-buffered UART transmitter. Words arrive on a valid/ready stream, are
// queued, and are serialised LSB first as start + data (+ parity) + stop
// (+ idle gap). Frames queued behind each other go out with no idle clk.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_data      : DATA_BITS word to transmit
//   in_valid     : in_data is valid; accepted on an edge with in_ready high
//   in_ready     : FIFO has room
//   tx           : serial line, idle high
//   busy         : high from the start bit through the end of the gap
//   frame_done   : one-clk pulse on the last clk of the frame
//   fifo_count   : queued words, not counting the frame in flight
// Build option: define UART_TX_STREAM_PARITY_EN to add a parity bit after the
// data bits (parameter PARITY_ODD: 0 = even, 1 = odd).
// -----------------------------------------------------------------------------
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE = 100000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int GAP_BITS   = 0
`ifdef UART_TX_STREAM_PARITY_EN
   ,
   parameter int PARITY_ODD = 0
`endif
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_BITS-1:0]           in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic                           tx,
   output logic                           busy,
   output logic                           frame_done,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
   localparam int DIV_W        = $clog2(CLKS_PER_BIT);

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [DIV_W-1:0] DIV_PRELAST = DIV_W'(CLKS_PER_BIT - 2);
   localparam logic [15:0]      DATA_LAST   = 16'(DATA_BITS - 1);
   localparam logic [15:0]      STOP_LAST   = 16'(STOP_BITS - 1);
   localparam logic [15:0]      GAP_LAST    = 16'(GAP_BITS - 1);

   if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_baud
      $error("uart_tx_stream: CLOCK_RATE/BAUD_RATE must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_stream: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_stream: STOP_BITS must be 1 or 2");
   end

   uart_tx_state_t         stateReg, stateNext;
   logic [DIV_W-1:0]       divReg, divNext;
   logic [15:0]            bitReg, bitNext;
   logic [DATA_BITS-1:0]   shiftReg, shiftNext;
   logic                   txReg, txNext;
   logic                   busyReg, busyNext;
   logic                   doneReg, doneNext;
`ifdef UART_TX_STREAM_PARITY_EN
   logic                   parityReg, parityNext;
`endif

   logic                   fifoPop;
   logic                   fifoFull;
   logic                   fifoEmpty;
   logic [DATA_BITS-1:0]   fifoRdata;
   logic                   bitEnd;
   logic                   endFrame;
   logic                   frameLastBit;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .pop   (fifoPop),
      .wdata (in_data),
      .rdata (fifoRdata),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .count (fifo_count)
   );

   assign bitEnd = (divReg == DIV_LAST);

   // Final bit-time of the frame: last gap bit, or last stop bit when there
   // is no gap (GAP_LAST never matches in that case).
   assign frameLastBit = (stateReg == GAP && bitReg == GAP_LAST) ||
                         (GAP_BITS == 0 && stateReg == STOP && bitReg == STOP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg  <= IDLE;
         divReg    <= '0;
         bitReg    <= '0;
         shiftReg  <= '0;
         txReg     <= 1'b1;
         busyReg   <= 1'b0;
         doneReg   <= 1'b0;
`ifdef UART_TX_STREAM_PARITY_EN
         parityReg <= 1'b0;
`endif
      end else begin
         stateReg  <= stateNext;
         divReg    <= divNext;
         bitReg    <= bitNext;
         shiftReg  <= shiftNext;
         txReg     <= txNext;
         busyReg   <= busyNext;
         doneReg   <= doneNext;
`ifdef UART_TX_STREAM_PARITY_EN
         parityReg <= parityNext;
`endif
      end
   end

   always_comb begin
      stateNext  = stateReg;
      divNext    = (stateReg == IDLE || bitEnd) ? '0 : divReg + DIV_W'(1);
      bitNext    = bitReg;
      shiftNext  = shiftReg;
      txNext     = txReg;
      busyNext   = busyReg;
      // Raised one clk early so the registered pulse lands on the frame's
      // last clk.
      doneNext   = frameLastBit && (divReg == DIV_PRELAST);
      fifoPop    = 1'b0;
      endFrame   = 1'b0;
`ifdef UART_TX_STREAM_PARITY_EN
      parityNext = parityReg;
`endif

      case (stateReg)
         IDLE: begin
         end
         START: begin
            if (bitEnd) begin
               stateNext = DATA;
               txNext    = shiftReg[0];
               bitNext   = '0;
            end
         end
         DATA: begin
            if (bitEnd) begin
               if (bitReg == DATA_LAST) begin
                  bitNext   = '0;
`ifdef UART_TX_STREAM_PARITY_EN
                  stateNext = PARITY;
                  txNext    = parityReg;
`else
                  stateNext = STOP;
                  txNext    = 1'b1;
`endif
               end else begin
                  bitNext   = bitReg + 16'd1;
                  shiftNext = shiftReg >> 1;
                  txNext    = shiftReg[1];
               end
            end
         end
`ifdef UART_TX_STREAM_PARITY_EN
         PARITY: begin
            if (bitEnd) begin
               stateNext = STOP;
               txNext    = 1'b1;
               bitNext   = '0;
            end
         end
`endif
         STOP: begin
            if (bitEnd) begin
               if (bitReg == STOP_LAST) begin
                  if (GAP_BITS > 0) begin
                     stateNext = GAP;
                     bitNext   = '0;
                  end else begin
                     endFrame = 1'b1;
                  end
               end else begin
                  bitNext = bitReg + 16'd1;
               end
            end
         end
         GAP: begin
            if (bitEnd) begin
               if (bitReg == GAP_LAST) begin
                  endFrame = 1'b1;
               end else begin
                  bitNext = bitReg + 16'd1;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      if (endFrame && fifoEmpty) begin
         stateNext = IDLE;
         busyNext  = 1'b0;
         txNext    = 1'b1;
      end

      // Load the next word either from idle or straight off the end of the
      // previous frame, which keeps queued frames contiguous.
      if ((stateReg == IDLE || endFrame) && !fifoEmpty) begin
         fifoPop    = 1'b1;
         shiftNext  = fifoRdata;
`ifdef UART_TX_STREAM_PARITY_EN
         parityNext = (^fifoRdata) ^ 1'(PARITY_ODD);
`endif
         txNext     = 1'b0;
         busyNext   = 1'b1;
         stateNext  = START;
         bitNext    = '0;
         divNext    = '0;
      end
   end

   assign in_ready   = !fifoFull;
   assign tx         = txReg;
   assign busy       = busyReg;
   assign frame_done = doneReg;

endmodule

// File: tb/tb_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_stream
// Bench for uart_tx_stream at CLOCK_RATE=1 MHz, BAUD_RATE=100 kHz (10 clks per
// bit). A cycle-level reference model (queue of accepted words plus the start
// time of the frame on the line) predicts every output of the main instance;
// directed sequences cover the table of known line patterns, back-to-back
// frames with a full FIFO, a 7-bit/2-stop/3-gap configuration and reset in
// the middle of a frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_stream;

`ifdef UART_TX_STREAM_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int CPB       = 10;
   localparam int DEPTH     = 4;
   localparam int FRAME     = CPB * (1 + 8 + P + 1);
   localparam int CFG_FRAME = CPB * (1 + 7 + P + 2 + 3);

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] inData;
   logic       inValid;
   logic       inReady, tx, busy, frameDone;
   logic [2:0] fifoCount;

   logic [6:0] cfgData;
   logic       cfgValid;
   logic       cfgReady, cfgTx, cfgBusy, cfgDone;
   logic [2:0] cfgCount;

   int total = 0;
   int bad   = 0;
   bit chkOn = 1'b0;

   always #5 clk = ~clk;

   uart_tx_stream #(
      .CLOCK_RATE (1000000), .BAUD_RATE (100000), .DATA_BITS (8),
      .STOP_BITS  (1),       .FIFO_DEPTH (DEPTH), .GAP_BITS  (0)
`ifdef UART_TX_STREAM_PARITY_EN
      , .PARITY_ODD (0)
`endif
   ) dut (
      .clk (clk), .rst_n (rst_n), .in_data (inData), .in_valid (inValid),
      .in_ready (inReady), .tx (tx), .busy (busy), .frame_done (frameDone),
      .fifo_count (fifoCount)
   );

   uart_tx_stream #(
      .CLOCK_RATE (1000000), .BAUD_RATE (100000), .DATA_BITS (7),
      .STOP_BITS  (2),       .FIFO_DEPTH (4),     .GAP_BITS  (3)
`ifdef UART_TX_STREAM_PARITY_EN
      , .PARITY_ODD (0)
`endif
   ) dutCfg (
      .clk (clk), .rst_n (rst_n), .in_data (cfgData), .in_valid (cfgValid),
      .in_ready (cfgReady), .tx (cfgTx), .busy (cfgBusy), .frame_done (cfgDone),
      .fifo_count (cfgCount)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model (main instance) ----------------
   int         cyc;
   bit         act;
   int         actStart;
   logic [7:0] actWord;
   logic [7:0] mq[$];
   int         mN;
   bit         mEnding;

   // Expected line level at clk offset 'off' into a frame carrying word w.
   function automatic logic expBit(input logic [7:0] w, input int off);
      int idx;
      idx = off / CPB;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return w[idx-1];
      if (P == 1 && idx == 9) return ^w;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         act = 1'b0;
         cyc = 0;
      end else begin
         cyc++;
         mN = mq.size();
         mEnding = act && (cyc - actStart == FRAME);
         if ((!act || mEnding) && mN > 0) begin
            actWord  = mq.pop_front();
            act      = 1'b1;
            actStart = cyc;
         end else if (mEnding) begin
            act = 1'b0;
         end
         if (inValid && mN != DEPTH) mq.push_back(inData);
      end
   end

   always @(negedge clk) begin
      if (chkOn) begin
         chk("m_tx",         tx,        act ? expBit(actWord, cyc - actStart) : 1'b1);
         chk("m_busy",       busy,      act);
         chk("m_frame_done", frameDone, act && (cyc - actStart == FRAME - 1));
         chk("m_in_ready",   inReady,   mq.size() != DEPTH);
         chk("m_fifo_count", fifoCount, mq.size());
      end
   end

   // ---------------- directed helpers ----------------
   typedef struct {
      logic [7:0] data;
      logic [9:0] line;   // bit i = i-th bit-time on the wire (start..stop)
      logic       par;    // even parity bit
   } vec_t;

   vec_t vecs[6];

   task automatic waitIdle();
      int n = 0;
      @(negedge clk);
      while ((busy !== 1'b0 || fifoCount !== 3'd0 || cfgBusy !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", n < 3000, 1);
   endtask

   initial begin
      int doneAt, lowAt, idx, acc, t, sixthAt, firstDone, dones, peak;
      int busyStart, busyEnd;
      logic e, hs, anyLow;

      vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
      vecs[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
      vecs[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
      vecs[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
      vecs[4] = '{8'h80, 10'b1_10000000_0, 1'b1};
      vecs[5] = '{8'h3C, 10'b1_00111100_0, 1'b0};

      rst_n = 1'b0; inValid = 1'b0; inData = '0; cfgValid = 1'b0; cfgData = '0;
      repeat (3) @(negedge clk);
      chkOn = 1'b1;
      chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_done", frameDone, 0);
      chk("rst_ready", inReady, 1); chk("rst_count", fifoCount, 0);
      chk("rst_cfg_tx", cfgTx, 1); chk("rst_cfg_ready", cfgReady, 1);
      rst_n = 1'b1;

      // ---- table-driven single frames ----
      for (int i = 0; i < 6; i++) begin
         waitIdle();
         inData = vecs[i].data; inValid = 1'b1;
         chk($sformatf("tbl%0d_ready", i), inReady, 1);
         @(posedge clk);
         @(negedge clk);
         inValid = 1'b0;
         doneAt = -1; lowAt = -1;
         for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            if (lowAt < 0 && tx == 1'b0) lowAt = k;
            if (frameDone && doneAt < 0) doneAt = k;
            if ((k - 1) % CPB == 5 && k <= FRAME) begin
               idx = (k - 1) / CPB;
               if (idx <= 8)                e = vecs[i].line[idx];
               else if (P == 1 && idx == 9) e = vecs[i].par;
               else                         e = vecs[i].line[9];
               chk($sformatf("tbl%0d_bit%0d", i, idx), tx, e);
            end
         end
         chk($sformatf("tbl%0d_first_low", i), lowAt, 1);
         chk($sformatf("tbl%0d_done_at", i), doneAt, FRAME);
         chk($sformatf("tbl%0d_busy_end", i), busy, 0);
      end

      // ---- back-to-back with a full FIFO ----
      waitIdle();
      acc = 0; t = 0; sixthAt = -1; firstDone = -1; dones = 0; peak = 0;
      busyStart = -1; busyEnd = -1;
      inData = 8'h01; inValid = 1'b1;
      while (t < 1500 && (acc < 6 || busy || fifoCount != 0)) begin
         hs = inValid && inReady;
         @(negedge clk);
         t++;
         if (hs) begin
            acc++;
            if (acc == 5) chk("b2b_ready_after5", inReady, 0);
            if (acc == 6) sixthAt = t;
         end
         inValid = (acc < 6);
         inData  = 8'(acc + 1);
         if (frameDone && firstDone < 0) firstDone = t;
         if (frameDone) dones++;
         if (fifoCount > peak) peak = fifoCount;
         if (busy && busyStart < 0) busyStart = t;
         if (busyStart >= 0 && !busy && busyEnd < 0) busyEnd = t;
      end
      inValid = 1'b0;
      chk("b2b_bound", t < 1500, 1);
      chk("b2b_accepted", acc, 6);
      chk("b2b_sixth_after_done", (firstDone > 0) && (sixthAt > firstDone), 1);
      chk("b2b_done_pulses", dones, 6);
      chk("b2b_peak_count", peak, DEPTH);
      chk("b2b_contiguous", busyEnd - busyStart, 6 * FRAME);

      // ---- randomised traffic against the model ----
      for (int c = 0; c < 3000; c++) begin
         inValid = ($urandom_range(0, 99) < 3);
         inData  = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      inValid = 1'b0;
      waitIdle();

      // ---- 7 data bits, 2 stop bits, 3 gap bits ----
      cfgData = 7'h7F; cfgValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cfgValid = 1'b0;
      doneAt = -1;
      for (int k = 1; k <= CFG_FRAME + 1; k++) begin
         @(negedge clk);
         if (cfgDone && doneAt < 0) doneAt = k;
         if ((k - 1) % CPB == 5 && k <= CFG_FRAME)
            chk($sformatf("cfg_bit%0d", (k - 1) / CPB), cfgTx, (k - 1) / CPB != 0);
      end
      chk("cfg_done_at", doneAt, CFG_FRAME);
      chk("cfg_busy_end", cfgBusy, 0);

      // ---- reset in the middle of a frame ----
      waitIdle();
      inValid = 1'b1; inData = 8'h11;
      @(negedge clk); inData = 8'h22;
      @(negedge clk); inData = 8'h33;
      @(negedge clk); inValid = 1'b0;
      repeat (33) @(negedge clk);
      chk("mid_busy_before", busy, 1);
      chk("mid_count_before", fifoCount, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_count", fifoCount, 0);
      chk("mid_rst_done", frameDone, 0);
      @(negedge clk);
      rst_n = 1'b1;
      anyLow = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (tx == 1'b0 || busy) anyLow = 1'b1;
      end
      chk("mid_no_frame_after", anyLow, 0);
      inData = 8'h5A; inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      @(negedge clk);
      chk("mid_new_push_starts", busy, 1);
      waitIdle();

      chkOn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Parametrised, FIFO-buffered UART transmitter; successor to the fixed 8N1 test-pattern transmitter top.
- Accepts words over a valid/ready stream, queues them in an internal synchronous FIFO and serialises them on `tx`.
- Data width, stop bits, FIFO depth and inter-frame gap are configurable. The bit timing divider is internal.
- Sits between any byte/word producer (pattern generator, packetiser) and the board TX pin.

Parameters:
- CLOCK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate. CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE (integer truncation); must be >= 2 (elaboration error otherwise).
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- GAP_BITS, 0, extra idle (high) bit-times inserted after each frame's stop bits.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset, synchronously deasserted externally.
- in_data  in  DATA_BITS  word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word; a transfer occurs on an edge where in_valid && in_ready.
- tx  out  1  serial line, idle high, LSB first.
- busy  out  1  high from the start bit through the end of the gap.
- frame_done  out  1  one-clk pulse on the last clk of the final stop/gap bit-time.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued words, excluding the frame in flight.

Behaviour:
- Reset values (async on rst_n low): tx=1, busy=0, frame_done=0, in_ready=1, fifo_count=0, FIFO pointers=0, FSM=IDLE, bit counter=0, clk divider=0.
- Reset mid-frame aborts the frame; tx goes high immediately. Queued data is discarded.
- FIFO write rules:
  - Write on in_valid && in_ready.
  - in_ready = (fifo_count != FIFO_DEPTH), registered-state based.
  - When full, a simultaneous pop does NOT enable a same-cycle push.
  - Write while empty together with a pop cannot occur, because the FSM pops only when it sees a non-empty FIFO.
- fifo_count is +1 on push only, -1 on pop only, and unchanged on push+pop in the same edge. It never wraps.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, GAP.
  - IDLE: if fifo_count != 0, then on the next edge pop the head into the shift register, set tx=0 and busy=1, and go to START.
  - Latency: a word pushed into an empty idle block at edge N puts tx low at edge N+1.
  - Every bit-time is exactly CLKS_PER_BIT clks. The divider counts 0..CLKS_PER_BIT-1, runs only outside IDLE, and is cleared on entering START.
  - START -> DATA after 1 bit-time.
  - DATA: shift out DATA_BITS bits LSB first, then go to PARITY or STOP.
  - STOP: tx=1 for STOP_BITS bit-times, then go to GAP if GAP_BITS > 0, else to the end-of-frame decision.
  - GAP: tx=1 for GAP_BITS bit-times.
  - End of frame: pulse frame_done. If the FIFO is non-empty, pop and go directly to START with no idle clk (back-to-back frames). Otherwise go to IDLE with busy=0.
- Frame length in clks is CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS+GAP_BITS), where P=1 with parity, else 0.
- Unused upper bits do not exist: the width is exactly DATA_BITS.

Optional Feature:
- Macro: UART_TX_STREAM_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0; 0=even, 1=odd).
  - A PARITY bit-time is inserted after DATA. Its value is the XOR of the payload, XOR PARITY_ODD.
- Undefined: no PARITY state and no parity logic; frame is start+data+stop(+gap).

Decomposition:
- Package uart_pkg:
  - State typedef uart_tx_state_t.
  - Function clks_per_bit(clock_rate, baud_rate).
  - Constant for the minimum CLKS_PER_BIT (2).
- Sub-module uart_sync_fifo, parametrised by WIDTH and DEPTH:
  - Ports: push, pop, wdata, rdata (show-ahead), full, empty, count.
- Divider and FSM stay in uart_tx_stream.

Test Plan:
All scenarios use CLOCK_RATE=1000000 and BAUD_RATE=100000 (CLKS_PER_BIT=10).
- Single byte, defaults: push 0xA5 at edge N.
  - tx low from N+1.
  - Line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 10 clks.
  - frame_done pulses at clk N+100; busy=0 from N+101; in_ready stays 1.
- Back-to-back: FIFO_DEPTH=4, push 6 words 0x01..0x06 on consecutive clks.
  - in_ready drops after the 5th accept; the 6th is held until the first frame_done.
  - All 6 frames are contiguous (start bit immediately after stop); fifo_count peaks at 4.
- Config: DATA_BITS=7, STOP_BITS=2, GAP_BITS=3, push 0x7F.
  - Frame = 0, seven 1s, then 1 held 50 clks; total 130 clks to frame_done.
- UART_TX_STREAM_PARITY_EN with PARITY_ODD=0:
  - 0xA5 gives parity bit 0; 0x07 gives parity bit 1. Each frame is 110 clks.
- Reset mid-frame: assert rst_n low at clk 35 of a frame with 2 words queued.
  - tx=1 within the same cycle, fifo_count=0, busy=0.
  - After release, no frame is sent until a new push.
